// File: rtl/frame_energy_meter.sv
// Frame energy meter: reads one frame of DEPTH samples from a latency-RD_LAT
// source, accumulating the sum of squares and the peak magnitude, then holds
// the result under a valid/ready handshake.
`timescale 1ns / 1ps

module frame_energy_meter #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned RD_LAT = 2
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             buffer_ready_i,
    input  logic                             read_enable_i,
    input  logic [WIDTH-1:0]                 read_data_i,
    output logic                             read_ack_o,
    output logic [2*WIDTH+$clog2(DEPTH)-1:0] energy_o,
    output logic [WIDTH-1:0]                 peak_o,
    output logic                             result_valid_o,
    input  logic                             result_ready_i,
    output logic                             busy_o,
    output logic                             overrun_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned EW = 2 * WIDTH + AW;
    localparam int unsigned LW = $clog2(RD_LAT + 1);

    localparam logic [LW-1:0] LAT_LOAD = LW'(RD_LAT);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StWait = 2'd1;
    localparam logic [1:0] StAck  = 2'd2;
    localparam logic [1:0] StDone = 2'd3;

    logic [1:0]              r_state;
    logic [1:0]              w_state_d;
    logic [LW-1:0]           r_lat;
    logic [LW-1:0]           w_lat_dec;
    logic [AW-1:0]           r_count;
    logic [EW-1:0]           r_acc_energy;
    logic [WIDTH-1:0]        r_acc_peak;
    logic [EW-1:0]           r_energy;
    logic [WIDTH-1:0]        r_peak;
    logic                    r_overrun;

    logic                    w_start;
    logic                    w_sample;
    logic                    w_last;
    logic                    w_ovr_set;
    logic signed [WIDTH-1:0] w_x;
    logic signed [2*WIDTH-1:0] w_prod;
    logic [EW-1:0]           w_sq;
    logic [WIDTH-1:0]        w_abs;
    logic [EW-1:0]           w_energy_sum;
    logic [WIDTH-1:0]        w_peak_next;

    // Sample arithmetic: the square of a two's-complement value is never
    // negative, so the product is zero-extended into the accumulator width.
    assign w_x          = read_data_i;
    assign w_prod       = w_x * w_x;
    assign w_sq         = {{AW{1'b0}}, w_prod};
    // Negating the most negative value wraps back onto 2^(WIDTH-1), which is
    // exactly its magnitude when read as unsigned.
    assign w_abs        = read_data_i[WIDTH-1] ? (~read_data_i + WIDTH'(1)) : read_data_i;
    assign w_energy_sum = r_acc_energy + w_sq;
    assign w_peak_next  = (w_abs > r_acc_peak) ? w_abs : r_acc_peak;
    assign w_lat_dec    = (r_lat == '0) ? '0 : r_lat - LW'(1);

    // Next-state decode plus the start/sample/overrun strobes.
    always_comb begin
        w_state_d = r_state;
        w_start   = 1'b0;
        w_sample  = 1'b0;
        w_last    = 1'b0;
        w_ovr_set = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (buffer_ready_i) w_start = 1'b1;
            end
            StWait: begin
                if (buffer_ready_i) begin
                    w_start   = 1'b1;
                    w_ovr_set = 1'b1;
                end else if (w_lat_dec == '0 && read_enable_i) begin
                    w_state_d = StAck;
                end
            end
            StAck: begin
                // A new frame pre-empts the ack, so the source never advances.
                if (buffer_ready_i) begin
                    w_start   = 1'b1;
                    w_ovr_set = 1'b1;
                end else begin
                    w_sample = 1'b1;
                    if (r_count == LAST_IDX) begin
                        w_last    = 1'b1;
                        w_state_d = StDone;
                    end else begin
                        w_state_d = StWait;
                    end
                end
            end
            StDone: begin
                if (result_ready_i) begin
                    if (buffer_ready_i) w_start = 1'b1;
                    else                w_state_d = StIdle;
                end else if (buffer_ready_i) begin
                    w_ovr_set = 1'b1;
                end
            end
            default: w_state_d = StIdle;
        endcase
        if (w_start) w_state_d = StWait;
    end

    // State, latency counter, sample count and accumulators.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state      <= StIdle;
            r_lat        <= '0;
            r_count      <= '0;
            r_acc_energy <= '0;
            r_acc_peak   <= '0;
        end else begin
            r_state <= w_state_d;
            if (w_start) begin
                r_lat        <= LAT_LOAD;
                r_count      <= '0;
                r_acc_energy <= '0;
                r_acc_peak   <= '0;
            end else if (w_sample) begin
                r_acc_energy <= w_energy_sum;
                r_acc_peak   <= w_peak_next;
                if (!w_last) begin
                    r_count <= r_count + AW'(1);
                    r_lat   <= LAT_LOAD;
                end
            end else if (r_state == StWait) begin
                r_lat <= w_lat_dec;
            end
        end
    end

    // Published result, updated only when the last sample lands; sticky overrun.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_energy  <= '0;
            r_peak    <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_last) begin
                r_energy <= w_energy_sum;
                r_peak   <= w_peak_next;
            end
            if (w_ovr_set) r_overrun <= 1'b1;
        end
    end

    assign read_ack_o     = w_sample;
    assign result_valid_o = (r_state == StDone);
    assign busy_o         = (r_state == StWait) || (r_state == StAck);
    assign energy_o       = r_energy;
    assign peak_o         = r_peak;
    assign overrun_o      = r_overrun;

endmodule

// File: doc/frame_energy_meter.md
FRAME_ENERGY_METER -- requirements
Module: frame_energy_meter

Interface
REQ-001 SHALL have parameter WIDTH, default 16, sample width in bits (two's-complement samples).
REQ-002 SHALL have parameter DEPTH, default 256, samples per frame (power of two, >=2); AW = log2(DEPTH).
REQ-003 SHALL have parameter RD_LAT, default 2, number of cycles from a read-address change to valid read data (>=1).
REQ-004 SHALL have ports:
  clk_i  in  1  single clock; all state updates on rising edge.
  rst_ni  in  1  reset, asynchronous and active-low.
  buffer_ready_i  in  1  one-cycle pulse: new frame available, read address reset to 0.
  read_enable_i  in  1  frame source has readable data.
  read_data_i  in  WIDTH  sample at the current read address.
  read_ack_o  out  1  one-cycle pulse: sample consumed, source advances its address.
  energy_o  out  2*WIDTH+AW  sum of squares of the frame's samples.
  peak_o  out  WIDTH  maximum absolute sample value of the frame, unsigned.
  result_valid_o  out  1  energy_o and peak_o are valid.
  result_ready_i  in  1  downstream accepts the result.
  busy_o  out  1  a frame is being read.
  overrun_o  out  1  sticky flag: a frame arrived while not IDLE and the result was not accepted.

Function
REQ-005 SHALL implement the FSM states IDLE, WAIT, ACK and DONE.
REQ-006 IDLE: on buffer_ready_i, SHALL clear the accumulators and the sample count, load the latency counter with RD_LAT, and go to WAIT.
REQ-007 WAIT: SHALL decrement the latency counter to 0, then go to ACK on the first cycle with read_enable_i=1; with read_enable_i=0 it SHALL hold in WAIT.
REQ-008 ACK: SHALL drive read_ack_o=1 for exactly this one cycle and sample read_data_i in the same cycle.
REQ-009 ACK: SHALL go to DONE if count==DEPTH-1; otherwise it SHALL increment the count, reload the latency counter with RD_LAT, and go to WAIT.
REQ-010 read_ack_o SHALL be high only in ACK, giving exactly DEPTH pulses per completed frame.
REQ-011 On each sample x, SHALL add x*x (signed multiply, unsigned result) to energy, with exact width 2*WIDTH+AW and no wrap or saturation.
REQ-012 SHALL compute |x| in WIDTH unsigned bits, with |-2^(WIDTH-1)| = 2^(WIDTH-1); peak SHALL be updated if |x| > peak.
REQ-013 DONE: SHALL hold result_valid_o=1 and keep energy_o and peak_o stable until result_ready_i=1, then go to IDLE.
REQ-014 energy_o and peak_o SHALL change only on the transition into DONE and SHALL hold their last values otherwise.
REQ-015 busy_o SHALL be 1 in WAIT and ACK, and 0 otherwise.
REQ-016 buffer_ready_i in WAIT or ACK SHALL abort the frame, set overrun_o, and restart as in REQ-006; no read_ack_o is issued that cycle.
REQ-017 buffer_ready_i in DONE with result_ready_i=0 SHALL set overrun_o and drop the new frame; the result is retained.
REQ-018 buffer_ready_i in DONE with result_ready_i=1 SHALL complete the handshake and start the new frame (to WAIT) with no overrun.
REQ-019 Sustained throughput: one sample per RD_LAT+1 cycles.

Reset
REQ-020 rst_ni=0 SHALL asynchronously force IDLE and clear to 0: read_ack_o, result_valid_o, busy_o, overrun_o, energy_o, peak_o, all accumulators and counters.
REQ-021 Reset asserted mid-frame SHALL discard the frame, with no read_ack_o after reset deasserts until the next buffer_ready_i.
REQ-022 overrun_o SHALL clear only on reset.

Verification
REQ-023 Frame of DEPTH samples, all +3 -> 256 read_ack_o pulses spaced 3 cycles apart; energy_o=2304; peak_o=3; result_valid_o set 1 cycle after the last ack.
REQ-024 Frame of alternating -32768/+32767 -> peak_o=32768; energy_o=128*2^30+128*32767^2=274869518464.
REQ-025 read_enable_i held 0 for 10 cycles mid-frame -> FSM holds in WAIT with no acks; results unchanged versus the uninterrupted frame.
REQ-026 buffer_ready_i at sample 100 -> overrun_o=1; count restarts; final result covers only the new 256 samples.
REQ-027 result_ready_i=0 when the next buffer_ready_i arrives -> overrun_o=1 and the result stays valid; with result_ready_i=1 in the same cycle -> no overrun and the new frame starts.
REQ-028 rst_ni pulsed low at sample 50 -> all outputs 0 immediately; no acks until the next buffer_ready_i.
